// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the AXI read arbiter
//
// Purpose: AXI field widths, default source IDs, AR FSM state encoding,
//          the AR holding-register layout and one-hot grant bit positions.
// Ports:   none (package).
package axi_arb_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  localparam logic [ID_W-1:0] ID_I_DEFAULT = 4'd0;
  localparam logic [ID_W-1:0] ID_D_DEFAULT = 4'd1;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_hold_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - bus bundle between two cache read ports and one AXI master
//
// Purpose: groups the i-cache AR/R, d-cache AR/R and AXI master AR/R
//          channels plus the err_rid flag.
// Modports:
//   slave  - arbiter view: consumes source AR and master R, drives source R,
//            master AR, m_rready and err_rid.
//   master - environment view: the mirror image of slave.
interface axi_read_arbiter_if;
  import axi_arb_pkg::*;

  logic [ADDR_W-1:0] i_araddr;
  logic [LEN_W-1:0]  i_arlen;
  logic [SIZE_W-1:0] i_arsize;
  logic              i_arvalid;
  logic              i_arready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rlast;
  logic              i_rvalid;
  logic              i_rready;

  logic [ADDR_W-1:0] d_araddr;
  logic [LEN_W-1:0]  d_arlen;
  logic [SIZE_W-1:0] d_arsize;
  logic              d_arvalid;
  logic              d_arready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rlast;
  logic              d_rvalid;
  logic              d_rready;

  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [LEN_W-1:0]  m_arlen;
  logic [SIZE_W-1:0] m_arsize;
  logic              m_arvalid;
  logic              m_arready;
  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  logic              err_rid;

  modport slave (
    input  i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    output i_arready, i_rdata, i_rlast, i_rvalid,
    input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    output d_arready, d_rdata, d_rlast, d_rvalid,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rlast, m_rvalid,
    output err_rid
  );

  modport master (
    output i_araddr, i_arlen, i_arsize, i_arvalid, i_rready,
    input  i_arready, i_rdata, i_rlast, i_rvalid,
    output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
    input  d_arready, d_rdata, d_rlast, d_rvalid,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rlast, m_rvalid,
    input  err_rid
  );

endinterface

// File: rtl/rd_grant_arb.sv
// rtl/rd_grant_arb.sv - two-input read grant arbiter, one-hot output
//
// Purpose: picks one of the i-cache / d-cache requests.
//   ARB_RR_EN defined   : round-robin, last-granted source loses a tie;
//                         history resets to "i last" so d wins the first tie.
//   ARB_RR_EN undefined : fixed priority, d-cache wins every tie.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   req_i, req_d   - eligible requests
//   accept         - the current grant is being taken this cycle
//   grant[1:0]     - one-hot grant (GNT_I / GNT_D), zero when no request
module rd_grant_arb
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef ARB_RR_EN
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (accept) begin
      last_d_q <= grant[GNT_D];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (req_i && req_d) begin
      if (last_d_q) grant[GNT_I] = 1'b1;
      else          grant[GNT_D] = 1'b1;
    end else if (req_d) begin
      grant[GNT_D] = 1'b1;
    end else if (req_i) begin
      grant[GNT_I] = 1'b1;
    end
  end
`else
  // Fixed priority keeps no history, so the clock and accept go unused.
  logic unused_inputs;
  assign unused_inputs = clk ^ rst_n ^ accept;

  always_comb begin
    grant = 2'b00;
    if (req_d) begin
      grant[GNT_D] = 1'b1;
    end else if (req_i) begin
      grant[GNT_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - merges i-cache and d-cache read bursts onto one AXI master
//
// Purpose: accepts one AR at a time from either cache, issues it on the master
//          AR channel with the source's ID, and routes R beats back by ID.
//          Each source may have a single burst outstanding; both may overlap
//          and their R beats may interleave. Grant policy selected by
//          macro ARB_RR_EN (round-robin) or its absence (fixed, d first).
// Parameters: ID_I, ID_D - AXI IDs used for i-cache and d-cache bursts.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   bus    - axi_read_arbiter_if.slave: i_* and d_* cache AR/R channels,
//            m_* AXI master AR/R channels, sticky err_rid.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_I = ID_I_DEFAULT,
  parameter logic [ID_W-1:0] ID_D = ID_D_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_read_arbiter_if.slave     bus
);

  ar_state_e  state_q;
  ar_hold_t   hold_q;
  logic       m_arvalid_q;

  logic       i_busy;
  logic       d_busy;
  logic       err_rid_q;

  logic       elig_i;
  logic       elig_d;
  logic [1:0] grant;
  logic       in_idle;
  logic       accept;
  logic       i_hs;
  logic       d_hs;

  logic       own_i;
  logic       own_d;
  logic       r_fire;

  // Busy is the registered value, so a burst completing this cycle makes its
  // source eligible again only from the next cycle.
  assign elig_i  = bus.i_arvalid & ~i_busy;
  assign elig_d  = bus.d_arvalid & ~d_busy;
  assign in_idle = (state_q == AR_IDLE);
  assign i_hs    = rst_n & in_idle & grant[GNT_I];
  assign d_hs    = rst_n & in_idle & grant[GNT_D];
  assign accept  = i_hs | d_hs;

  rd_grant_arb u_grant (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (elig_i),
    .req_d  (elig_d),
    .accept (accept),
    .grant  (grant)
  );

  assign bus.i_arready = i_hs;
  assign bus.d_arready = d_hs;

  // AR channel FSM: one request held in flight on the master at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= AR_IDLE;
      hold_q      <= '0;
      m_arvalid_q <= 1'b0;
    end else begin
      case (state_q)
        AR_IDLE: begin
          if (accept) begin
            state_q     <= AR_SEND;
            m_arvalid_q <= 1'b1;
            if (d_hs) begin
              hold_q.id   <= ID_D;
              hold_q.addr <= bus.d_araddr;
              hold_q.len  <= bus.d_arlen;
              hold_q.size <= bus.d_arsize;
            end else begin
              hold_q.id   <= ID_I;
              hold_q.addr <= bus.i_araddr;
              hold_q.len  <= bus.i_arlen;
              hold_q.size <= bus.i_arsize;
            end
          end
        end
        AR_SEND: begin
          if (bus.m_arready) begin
            state_q     <= AR_IDLE;
            m_arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= AR_IDLE;
          m_arvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_arvalid = m_arvalid_q & rst_n;
  assign bus.m_arid    = hold_q.id;
  assign bus.m_araddr  = hold_q.addr;
  assign bus.m_arlen   = hold_q.len;
  assign bus.m_arsize  = hold_q.size;

  // A beat belongs to a source only if the ID matches and that source has a
  // burst outstanding; anything else is swallowed with m_rready held high.
  assign own_i  = (bus.m_rid == ID_I) & i_busy;
  assign own_d  = (bus.m_rid == ID_D) & d_busy;

  assign bus.i_rvalid = rst_n & bus.m_rvalid & own_i;
  assign bus.d_rvalid = rst_n & bus.m_rvalid & own_d;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign bus.i_rlast  = bus.m_rlast;
  assign bus.d_rlast  = bus.m_rlast;

  assign bus.m_rready = own_i ? bus.i_rready :
                        own_d ? bus.d_rready : 1'b1;

  assign r_fire = bus.m_rvalid & bus.m_rready & bus.m_rlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_busy    <= 1'b0;
      d_busy    <= 1'b0;
      err_rid_q <= 1'b0;
    end else begin
      if (i_hs) begin
        i_busy <= 1'b1;
      end else if (r_fire && own_i) begin
        i_busy <= 1'b0;
      end
      if (d_hs) begin
        d_busy <= 1'b1;
      end else if (r_fire && own_d) begin
        d_busy <= 1'b0;
      end
      if (bus.m_rvalid && !own_i && !own_d) begin
        err_rid_q <= 1'b1;
      end
    end
  end

  assign bus.err_rid = err_rid_q;

endmodule
